// File: rtl/kb_pkg.sv
// kb_pkg: shared types and constants for the PS/2 keyboard frame controller.
//   kb_state_e       - receive FSM state encoding
//   PS2_PREFIX_EXT   - scan-code prefix marking an extended key
//   PS2_PREFIX_BREAK - scan-code prefix marking a key release
//   PS2_DATA_BITS    - data bits per PS/2 frame
package kb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } kb_state_e;

    localparam logic [7:0]  PS2_PREFIX_EXT   = 8'hE0;
    localparam logic [7:0]  PS2_PREFIX_BREAK = 8'hF0;
    localparam int unsigned PS2_DATA_BITS    = 8;

endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: brings PS2_CLK and SDATA into the CLK domain and flags the
// cycles in which the synchronized keyboard clock falls.
// Ports:
//   clk_i      - system clock
//   arst_i     - asynchronous active-high reset (chains reset to idle-high)
//   ps2_clk_i  - raw keyboard clock
//   sdata_i    - raw keyboard data
//   fall_o     - high for one cycle when synchronized PS2_CLK goes 1 -> 0
//   sdata_o    - synchronized keyboard data
module ps2_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic arst_i,
    input  logic ps2_clk_i,
    input  logic sdata_i,
    output logic fall_o,
    output logic sdata_o
);

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] dat_sync_q;
    logic                   clk_prev_q;

    // Both lines idle high on the PS/2 bus, so resetting to 1 avoids a false
    // falling edge right after reset release.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q[0] <= ps2_clk_i;
            dat_sync_q[0] <= sdata_i;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                clk_sync_q[i] <= clk_sync_q[i-1];
                dat_sync_q[i] <= dat_sync_q[i-1];
            end
            clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
        end
    end

    always_comb begin
        fall_o  = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
        sdata_o = dat_sync_q[SYNC_STAGES-1];
    end

endmodule

// File: rtl/kb_frame_ctrl.sv
// kb_frame_ctrl: PS/2 keyboard receiver. Deserializes 11-bit frames, strips
// E0/F0 prefixes into flags, and presents key events over a valid/ready port.
// Ports:
//   CLK, ARST            - system clock, asynchronous active-high reset
//   PS2_CLK, SDATA       - raw keyboard clock and data
//   EVT_READY            - consumer accepts the held event
//   EVT_VALID            - an event is held
//   EVT_CODE             - scan code with prefixes stripped
//   EVT_BREAK, EVT_EXT   - F0 / E0 prefix seen before this code
//   ERR_PARITY           - one-cycle pulse, parity failure
//   ERR_FRAME            - one-cycle pulse, bad start/stop bit or timeout
//   ERR_OVERRUN          - one-cycle pulse, event dropped under backpressure
//   BUSY                 - frame reception in progress
module kb_frame_ctrl
    import kb_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT_CYC = 5000
) (
    input  logic       CLK,
    input  logic       ARST,
    input  logic       PS2_CLK,
    input  logic       SDATA,
    input  logic       EVT_READY,
    output logic       EVT_VALID,
    output logic [7:0] EVT_CODE,
    output logic       EVT_BREAK,
    output logic       EVT_EXT,
    output logic       ERR_PARITY,
    output logic       ERR_FRAME,
    output logic       ERR_OVERRUN,
    output logic       BUSY
);

    localparam int unsigned CntW = $clog2(PS2_DATA_BITS);
    localparam int unsigned TmoW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);

    logic fall;
    logic sdata;

    ps2_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i    (CLK),
        .arst_i   (ARST),
        .ps2_clk_i(PS2_CLK),
        .sdata_i  (SDATA),
        .fall_o   (fall),
        .sdata_o  (sdata)
    );

    kb_state_e                state_q, state_d;
    logic [CntW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [PS2_DATA_BITS-1:0] shift_q, shift_d;
    logic                     par_ok_q, par_ok_d;
    logic                     ext_q, ext_d;
    logic                     brk_q, brk_d;
    logic [TmoW-1:0]          tmo_q, tmo_d;

    logic       evt_valid_q, evt_valid_d;
    logic [7:0] evt_code_q, evt_code_d;
    logic       evt_break_q, evt_break_d;
    logic       evt_ext_q, evt_ext_d;
    logic       err_parity_q, err_frame_q, err_overrun_q;

    logic byte_ok;
    logic frame_err;
    logic par_err;
    logic new_evt;
    logic overrun;

    // Receive FSM, prefix tracking and timeout.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_ok_d  = par_ok_q;
        ext_d     = ext_q;
        brk_d     = brk_q;
        tmo_d     = tmo_q;
        byte_ok   = 1'b0;
        frame_err = 1'b0;
        par_err   = 1'b0;
        new_evt   = 1'b0;

        if (state_q == StIdle || fall) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end

        if (fall) begin
            case (state_q)
                StIdle: begin
                    if (!sdata) begin
                        state_d   = StData;
                        bit_cnt_d = '0;
                    end else begin
                        frame_err = 1'b1;
                    end
                end
                StData: begin
                    // LSB arrives first, so shift in from the top.
                    shift_d   = {sdata, shift_q[PS2_DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == CntW'(PS2_DATA_BITS - 1)) begin
                        state_d = StParity;
                    end
                end
                StParity: begin
                    // Odd parity: data plus parity bit must hold an odd number of ones.
                    par_ok_d = ^{shift_q, sdata};
                    state_d  = StStop;
                end
                StStop: begin
                    state_d = StIdle;
                    if (!sdata) begin
                        frame_err = 1'b1;
                    end else if (!par_ok_q) begin
                        par_err = 1'b1;
                    end else begin
                        byte_ok = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end else if (state_q != StIdle && tmo_q == TmoW'(TIMEOUT_CYC - 1)) begin
            // This cycle is the TIMEOUT_CYC-th in a row without a falling edge.
            state_d   = StIdle;
            tmo_d     = '0;
            frame_err = 1'b1;
        end

        if (frame_err || par_err) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end

        if (byte_ok) begin
            if (shift_q == PS2_PREFIX_EXT) begin
                ext_d = 1'b1;
            end else if (shift_q == PS2_PREFIX_BREAK) begin
                brk_d = 1'b1;
            end else begin
                new_evt = 1'b1;
                ext_d   = 1'b0;
                brk_d   = 1'b0;
            end
        end
    end

    // Event holding register with valid/ready handshake.
    always_comb begin
        evt_valid_d = evt_valid_q;
        evt_code_d  = evt_code_q;
        evt_break_d = evt_break_q;
        evt_ext_d   = evt_ext_q;
        overrun     = 1'b0;

        if (evt_valid_q && EVT_READY) begin
            evt_valid_d = 1'b0;
        end

        if (new_evt) begin
            if (!evt_valid_q || EVT_READY) begin
                evt_valid_d = 1'b1;
                evt_code_d  = shift_q;
                evt_break_d = brk_q;
                evt_ext_d   = ext_q;
            end else begin
                overrun = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge ARST) begin
        if (ARST) begin
            state_q       <= StIdle;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            par_ok_q      <= 1'b0;
            ext_q         <= 1'b0;
            brk_q         <= 1'b0;
            tmo_q         <= '0;
            evt_valid_q   <= 1'b0;
            evt_code_q    <= '0;
            evt_break_q   <= 1'b0;
            evt_ext_q     <= 1'b0;
            err_parity_q  <= 1'b0;
            err_frame_q   <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            par_ok_q      <= par_ok_d;
            ext_q         <= ext_d;
            brk_q         <= brk_d;
            tmo_q         <= tmo_d;
            evt_valid_q   <= evt_valid_d;
            evt_code_q    <= evt_code_d;
            evt_break_q   <= evt_break_d;
            evt_ext_q     <= evt_ext_d;
            err_parity_q  <= par_err;
            err_frame_q   <= frame_err;
            err_overrun_q <= overrun;
        end
    end

    always_comb begin
        EVT_VALID   = evt_valid_q;
        EVT_CODE    = evt_code_q;
        EVT_BREAK   = evt_break_q;
        EVT_EXT     = evt_ext_q;
        ERR_PARITY  = err_parity_q;
        ERR_FRAME   = err_frame_q;
        ERR_OVERRUN = err_overrun_q;
        BUSY        = (state_q != StIdle);
    end

endmodule

// File: tb/tb_kb_frame_ctrl.sv
// Directed bench for kb_frame_ctrl: drives PS/2 frames bit by bit and checks
// events and error pulses against hand-computed values.
module tb_kb_frame_ctrl;

    localparam int SyncStages = 2;
    localparam int TimeoutCyc = 50;

    logic       CLK = 1'b0;
    logic       ARST;
    logic       PS2_CLK;
    logic       SDATA;
    logic       EVT_READY;
    logic       EVT_VALID;
    logic [7:0] EVT_CODE;
    logic       EVT_BREAK;
    logic       EVT_EXT;
    logic       ERR_PARITY;
    logic       ERR_FRAME;
    logic       ERR_OVERRUN;
    logic       BUSY;

    kb_frame_ctrl #(
        .SYNC_STAGES(SyncStages),
        .TIMEOUT_CYC(TimeoutCyc)
    ) dut (
        .CLK        (CLK),
        .ARST       (ARST),
        .PS2_CLK    (PS2_CLK),
        .SDATA      (SDATA),
        .EVT_READY  (EVT_READY),
        .EVT_VALID  (EVT_VALID),
        .EVT_CODE   (EVT_CODE),
        .EVT_BREAK  (EVT_BREAK),
        .EVT_EXT    (EVT_EXT),
        .ERR_PARITY (ERR_PARITY),
        .ERR_FRAME  (ERR_FRAME),
        .ERR_OVERRUN(ERR_OVERRUN),
        .BUSY       (BUSY)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // Monitor: counts consumed events and error-pulse cycles.
    int         ev_cnt  = 0;
    int         par_cnt = 0;
    int         frm_cnt = 0;
    int         ovr_cnt = 0;
    logic [7:0] last_code = 8'h00;
    logic       last_brk  = 1'b0;
    logic       last_ext  = 1'b0;
    int         ev0, par0, frm0, ovr0;

    always @(negedge CLK) begin
        if (!ARST) begin
            if (EVT_VALID && EVT_READY) begin
                ev_cnt++;
                last_code = EVT_CODE;
                last_brk  = EVT_BREAK;
                last_ext  = EVT_EXT;
            end
            if (ERR_PARITY)  par_cnt++;
            if (ERR_FRAME)   frm_cnt++;
            if (ERR_OVERRUN) ovr_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic snap();
        ev0  = ev_cnt;
        par0 = par_cnt;
        frm0 = frm_cnt;
        ovr0 = ovr_cnt;
    endtask

    // One PS/2 bit: data settles, clock low 8 cycles, clock high 4 cycles.
    task automatic ps2_bit(input logic b);
        SDATA = b;
        tick(4);
        PS2_CLK = 1'b0;
        tick(8);
        PS2_CLK = 1'b1;
        tick(4);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic flip_par, input logic stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit((~(^d)) ^ flip_par);
        ps2_bit(stop);
        tick(4);
    endtask

    function automatic logic [31:0] outs();
        return 32'({EVT_VALID, EVT_CODE, EVT_BREAK, EVT_EXT,
                    ERR_PARITY, ERR_FRAME, ERR_OVERRUN, BUSY});
    endfunction

    int first_k;
    logic busy_at_err;
    logic busy_before;

    initial begin
        ARST      = 1'b1;
        PS2_CLK   = 1'b1;
        SDATA     = 1'b1;
        EVT_READY = 1'b1;
        tick(3);
        check("rst_outputs", outs(), 32'h0);
        ARST = 1'b0;
        tick(5);
        check("post_rst_outputs", outs(), 32'h0);

        // Make code 1C with exact event latency after the stop-bit falling edge.
        snap();
        ps2_bit(1'b0);
        check("busy_in_frame", 32'(BUSY), 32'h1);
        for (int i = 0; i < 8; i++) ps2_bit(1'(8'h1C >> i));
        ps2_bit(1'b0);
        SDATA = 1'b1;
        tick(4);
        PS2_CLK = 1'b0;
        tick(SyncStages);
        check("evt_not_early", 32'(EVT_VALID), 32'h0);
        tick(1);
        check("evt_1c_valid", 32'(EVT_VALID), 32'h1);
        check("evt_1c_fields", 32'({EVT_CODE, EVT_BREAK, EVT_EXT}), 32'({8'h1C, 2'b00}));
        tick(1);
        check("evt_1c_consumed", 32'(EVT_VALID), 32'h0);
        tick(5);
        PS2_CLK = 1'b1;
        tick(8);
        check("evt_1c_count", 32'(ev_cnt - ev0), 32'd1);
        check("idle_after_frame", 32'(BUSY), 32'h0);

        // F0 then 1C: one break event.
        snap();
        send_frame(8'hF0, 1'b0, 1'b1);
        check("f0_no_event", 32'(ev_cnt - ev0), 32'd0);
        send_frame(8'h1C, 1'b0, 1'b1);
        check("brk_1c_count", 32'(ev_cnt - ev0), 32'd1);
        check("brk_1c_fields", 32'({last_code, last_brk, last_ext}), 32'({8'h1C, 2'b10}));

        // E0 F0 75 then plain 75.
        snap();
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h75, 1'b0, 1'b1);
        check("ext_brk_count", 32'(ev_cnt - ev0), 32'd1);
        check("ext_brk_fields", 32'({last_code, last_brk, last_ext}), 32'({8'h75, 2'b11}));
        send_frame(8'h75, 1'b0, 1'b1);
        check("plain_75_fields", 32'({last_code, last_brk, last_ext}), 32'({8'h75, 2'b00}));

        // Parity error clears a pending break.
        snap();
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h1C, 1'b1, 1'b1);
        check("par_err_pulse", 32'(par_cnt - par0), 32'd1);
        check("par_err_no_event", 32'(ev_cnt - ev0), 32'd0);
        send_frame(8'h1C, 1'b0, 1'b1);
        check("after_par_fields", 32'({last_code, last_brk, last_ext}), 32'({8'h1C, 2'b00}));
        check("after_par_no_frame_err", 32'(frm_cnt - frm0), 32'd0);

        // Bad stop bit, then a start bit of 1 in idle.
        snap();
        send_frame(8'h1C, 1'b0, 1'b0);
        check("stop0_frame_err", 32'(frm_cnt - frm0), 32'd1);
        check("stop0_no_event", 32'(ev_cnt - ev0), 32'd0);
        ps2_bit(1'b1);
        tick(4);
        check("start1_frame_err", 32'(frm_cnt - frm0), 32'd2);
        check("start1_idle", 32'(BUSY), 32'h0);

        // Timeout after 5 data bits.
        snap();
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        SDATA = 1'b0;
        tick(4);
        PS2_CLK = 1'b0;
        first_k = 0;
        busy_at_err = 1'b1;
        busy_before = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            tick(1);
            if (k == 10) PS2_CLK = 1'b1;
            if (k == SyncStages + TimeoutCyc) busy_before = BUSY;
            if (ERR_FRAME && first_k == 0) begin
                first_k     = k;
                busy_at_err = BUSY;
            end
        end
        check("tmo_latency", 32'(first_k), 32'(SyncStages + 1 + TimeoutCyc));
        check("tmo_busy_before", 32'(busy_before), 32'h1);
        check("tmo_busy_cleared", 32'(busy_at_err), 32'h0);
        check("tmo_one_pulse", 32'(frm_cnt - frm0), 32'd1);
        check("tmo_no_event", 32'(ev_cnt - ev0), 32'd0);
        send_frame(8'h1C, 1'b0, 1'b1);
        check("after_tmo_count", 32'(ev_cnt - ev0), 32'd1);
        check("after_tmo_fields", 32'({last_code, last_brk, last_ext}), 32'({8'h1C, 2'b00}));

        // Backpressure: second make code is dropped.
        snap();
        EVT_READY = 1'b0;
        send_frame(8'h1C, 1'b0, 1'b1);
        send_frame(8'h32, 1'b0, 1'b1);
        check("ovr_held_valid", 32'(EVT_VALID), 32'h1);
        check("ovr_held_fields", 32'({EVT_CODE, EVT_BREAK, EVT_EXT}), 32'({8'h1C, 2'b00}));
        check("ovr_one_pulse", 32'(ovr_cnt - ovr0), 32'd1);
        EVT_READY = 1'b1;
        tick(1);
        check("ovr_drained", 32'(EVT_VALID), 32'h0);
        check("ovr_consumed_code", 32'({ev_cnt - ev0, last_code}), 32'({24'd1, 8'h1C}));

        // Reset in the middle of a frame with a pending break.
        send_frame(8'hF0, 1'b0, 1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        snap();
        #3 ARST = 1'b1;
        #1 check("arst_async_outputs", outs(), 32'h0);
        tick(3);
        check("arst_held_outputs", outs(), 32'h0);
        ARST = 1'b0;
        tick(TimeoutCyc + 20);
        check("arst_release_outputs", outs(), 32'h0);
        check("arst_no_pulses", 32'((frm_cnt - frm0) + (par_cnt - par0) + (ovr_cnt - ovr0)),
              32'd0);
        send_frame(8'h1C, 1'b0, 1'b1);
        check("arst_cleared_prefix", 32'({last_code, last_brk, last_ext}), 32'({8'h1C, 2'b00}));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
